// File: rtl/class_argmax_seq.sv
// Sequential argmax over N_CLASS serially delivered unsigned scores.
// One shared comparator tracks the running maximum; the result is held until taken.
module class_argmax_seq #(
    parameter int N_CLASS = 10,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_value,
    output logic [1:0]        dbg_state
);

    // Handshakes: a score transfers on any rising edge where in_valid && in_ready;
    // a result transfers on any rising edge where out_valid && out_ready. Producers
    // hold valid and payload stable until the transfer; ready never depends on valid.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_best_val;
    logic [IDX_W-1:0]  r_best_idx;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_index;
    logic [DATA_W-1:0] r_out_value;
    logic              r_busy;

    state_t            w_state_nxt;
    logic [IDX_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_best_val_nxt;
    logic [IDX_W-1:0]  w_best_idx_nxt;
    logic              w_out_valid_nxt;
    logic [IDX_W-1:0]  w_out_index_nxt;
    logic [DATA_W-1:0] w_out_value_nxt;
    logic              w_busy_nxt;

    logic              w_accept;
    logic              w_take_new;
    logic [DATA_W-1:0] w_cand_val;
    logic [IDX_W-1:0]  w_cand_idx;

    assign in_ready  = (r_state == S_COLLECT);
    assign w_accept  = in_valid && in_ready;
    // Strict compare keeps the earliest index on ties; the first score always loads.
    assign w_take_new = (r_cnt == '0) || (in_data > r_best_val);
    assign w_cand_val = w_take_new ? in_data : r_best_val;
    assign w_cand_idx = w_take_new ? r_cnt : r_best_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_best_val_nxt  = r_best_val;
        w_best_idx_nxt  = r_best_idx;
        w_out_valid_nxt = r_out_valid;
        w_out_index_nxt = r_out_index;
        w_out_value_nxt = r_out_value;
        w_busy_nxt      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COLLECT;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_COLLECT: begin
                if (w_accept) begin
                    w_best_val_nxt = w_cand_val;
                    w_best_idx_nxt = w_cand_idx;
                    if (r_cnt == LAST_IDX) begin
                        w_state_nxt     = S_DONE;
                        w_out_valid_nxt = 1'b1;
                        w_out_index_nxt = w_cand_idx;
                        w_out_value_nxt = w_cand_val;
                        w_busy_nxt      = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    if (start) begin
                        w_state_nxt = S_COLLECT;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_value <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_best_val  <= w_best_val_nxt;
            r_best_idx  <= w_best_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_value <= w_out_value_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_value = r_out_value;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_class_argmax_seq.sv
// Bench for class_argmax_seq: directed and random score sets against an
// argmax reference (max value first, then lowest index holding it).
module tb_class_argmax_seq;

    localparam int N_CLASS = 10;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 8;
    localparam int W       = IDX_W + DATA_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_value;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] cur[N_CLASS];

    class_argmax_seq #(.N_CLASS(N_CLASS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_value(out_value), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model: find the largest score, then the lowest index that holds it
    function automatic logic [W-1:0] ref_argmax();
        int mx = 0;
        for (int i = 0; i < N_CLASS; i++) if (int'(cur[i]) > mx) mx = int'(cur[i]);
        for (int i = 0; i < N_CLASS; i++)
            if (int'(cur[i]) == mx) return {IDX_W'(i), DATA_W'(mx)};
        return '0;
    endfunction

    task automatic push_exp();
        exp_q.push_back(ref_argmax());
    endtask

    task automatic do_start();
        push_exp();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", 32'(dbg_state), 32'(ST_COLLECT));
        check("start_busy", 32'(busy), 1);
        check("start_out_valid", 32'(out_valid), 0);
    endtask

    // mode 0: continuous valid, 1: every other cycle, 2: random gaps
    task automatic collect(input int mode, input bit poke_start, input int n_acc);
        int acc = 0;
        int cyc = 0;
        int ready_cnt = 0;
        bit take;
        while (acc < n_acc && cyc < 400) begin
            case (mode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_data = in_valid ? cur[acc] : DATA_W'($urandom);
            start = poke_start && ($urandom_range(0, 2) == 0);
            if (in_ready) ready_cnt++;
            take = in_valid && in_ready;
            step();
            if (take) acc++;
            cyc++;
            if (acc < N_CLASS) begin
                check("collect_state", 32'(dbg_state), 32'(ST_COLLECT));
                check("collect_busy", 32'(busy), 1);
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("accept_budget", 32'(acc), 32'(n_acc));
        if (mode == 0 && n_acc == N_CLASS) check("ready_cycles", 32'(ready_cnt), N_CLASS);
    endtask

    task automatic finish(input int stall, input bit b2b);
        logic [W-1:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("done_out_valid", 32'(out_valid), 1);
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        check("done_busy", 32'(busy), 0);
        check("done_in_ready", 32'(in_ready), 0);
        check("out_index", 32'(out_index), 32'(exp[W-1:DATA_W]));
        check("out_value", 32'(out_value), 32'(exp[DATA_W-1:0]));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            start = (s == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            in_valid = 1'b1;
            in_data = DATA_W'($urandom);
            step();
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_state", 32'(dbg_state), 32'(ST_DONE));
            check("stall_index", 32'(out_index), 32'(exp[W-1:DATA_W]));
            check("stall_value", 32'(out_value), 32'(exp[DATA_W-1:0]));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = b2b;
        step();
        out_ready = 1'b0;
        start = 1'b0;
        check("taken_out_valid", 32'(out_valid), 0);
        check("taken_state", 32'(dbg_state), b2b ? 32'(ST_COLLECT) : 32'(ST_IDLE));
        check("taken_busy", 32'(busy), 32'(b2b));
        if (!b2b) check("taken_index_held", 32'(out_index), 32'(exp[W-1:DATA_W]));
    endtask

    task automatic load(input int kind);
        for (int i = 0; i < N_CLASS; i++) begin
            case (kind)
                0: cur[i] = '0;
                1: cur[i] = DATA_W'(i + 1);
                2: cur[i] = (i == N_CLASS - 1) ? 8'd255 : 8'd254;
                3: cur[i] = DATA_W'($urandom_range(0, 255));
                default: cur[i] = DATA_W'($urandom_range(0, 6));
            endcase
        end
    endtask

    // directed steps, then random runs
    initial begin
        bit pending_b2b;
        rst = 1'b1;
        step();
        step();
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_index", 32'(out_index), 0);
        check("rst_out_value", 32'(out_value), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;

        in_valid = 1'b1;
        step();
        check("idle_ignores_valid", 32'(dbg_state), 32'(ST_IDLE));
        in_valid = 1'b0;

        cur = '{8'd10, 8'd20, 8'd5, 8'd90, 8'd3, 8'd7, 8'd90, 8'd1, 8'd0, 8'd44};
        do_start();
        collect(0, 1'b0, N_CLASS);
        finish(0, 1'b0);

        do_start();
        collect(1, 1'b1, N_CLASS);
        finish(5, 1'b1);
        cur = '{8'd5, 8'd12, 8'd77, 8'd3, 8'd77, 8'd0, 8'd60, 8'd76, 8'd1, 8'd9};
        push_exp();
        collect(0, 1'b0, N_CLASS);
        finish(0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            load(k);
            do_start();
            collect(0, 1'b0, N_CLASS);
            finish(1, 1'b0);
        end

        load(3);
        do_start();
        collect(0, 1'b1, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_index", 32'(out_index), 0);
        check("midrst_out_value", 32'(out_value), 0);
        check("midrst_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            step();
            check("midrst_in_ready", 32'(in_ready), 0);
            check("midrst_no_result", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        do_start();
        collect(2, 1'b1, N_CLASS);
        finish(2, 1'b0);

        pending_b2b = 1'b0;
        for (int r = 0; r < 12; r++) begin
            bit b2b;
            load((r % 2 == 0) ? 3 : 4);
            if (pending_b2b) push_exp();
            else do_start();
            collect(2, 1'b1, N_CLASS);
            b2b = (r < 11) && ($urandom_range(0, 1) == 1);
            finish($urandom_range(0, 4), b2b);
            pending_b2b = b2b;
        end

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/class_argmax_seq.md
Name: class_argmax_seq

Overview:
- Sequential argmax controller for the output layer.
- Accepts N_CLASS output-neuron scores one per cycle over a valid/ready stream and tracks the running maximum with a single shared comparator.
- Returns the winning class index and its value through a held result handshake.
- Replaces the parallel comparator tree when output scores arrive serially from the time-multiplexed neuron datapath.

Parameters:
- N_CLASS, 10, number of scores per classification (2..255).
- DATA_W, 8, score width; unsigned.
- IDX_W, 8, class index width; must satisfy 2^IDX_W >= N_CLASS.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a classification; honoured only in IDLE, or in DONE together with out_ready.
- in_valid  in  1  score present on in_data.
- in_data  in  DATA_W  score of class k, where k = number of scores already accepted.
- in_ready  out  1  block can accept a score.
- busy  out  1  high in COLLECT.
- out_valid  out  1  result available; held until taken.
- out_ready  in  1  consumer takes the result.
- out_index  out  IDX_W  winning class index.
- out_value  out  DATA_W  winning score.

Behaviour:
- States: IDLE, COLLECT, DONE. All outputs registered, except in_ready = (state==COLLECT).
- Reset: rst sampled high at a clock edge gives state=IDLE, cnt=0, best_val=0, best_idx=0, out_valid=0, out_index=0, out_value=0, busy=0.
  - rst dominates all other inputs.
  - Reset mid-COLLECT or in DONE discards the partial or pending result; no out_valid follows.
- IDLE:
  - start=1 moves to COLLECT next cycle with cnt=0 and busy=1.
  - in_valid is ignored; in_ready=0.
- COLLECT: a score is accepted on a cycle with in_valid && in_ready.
  - First accepted score (cnt==0): best_val=in_data, best_idx=0 unconditionally.
  - Later scores: replace only if in_data > best_val (strict, unsigned); best_idx=cnt.
  - Tie rule: the earliest index wins.
  - cnt increments on each accept. in_valid gaps stall with no state change.
  - start is ignored in COLLECT; no restart.
- Last score: on the accept with cnt==N_CLASS-1, the next cycle is DONE.
  - In that cycle out_valid=1, out_index/out_value = final best including the last score, and busy=0.
  - Latency: out_valid rises 1 cycle after the last accept.
- DONE:
  - out_valid, out_index and out_value are held stable while out_ready=0.
  - out_ready=1 and start=0: next cycle IDLE, out_valid=0; out_index/out_value keep their last values.
  - out_ready=1 and start=1: next cycle COLLECT, out_valid=0, cnt=0 (back-to-back run).
  - start without out_ready is ignored.
- Counter: cnt width IDX_W; never exceeds N_CLASS-1. No wrap, because the state leaves COLLECT at the last accept.
- Arithmetic: compare only, no sign extension. A score of 0 can win, e.g. all-zero input gives index 0.

Test Plan:
- Basic: reset, start, stream 10,20,5,90,3,7,90,1,0,44 with in_valid continuous. Required: in_ready high for exactly 10 cycles; out_valid 1 cycle after the 10th accept; out_index=3 and out_value=90 (tie with index 6 resolves to the earlier one).
- Stalls and backpressure: same data with in_valid deasserted every other cycle, and out_ready held 0 for 5 cycles in DONE. Required: identical result; out_* stable across all 5 stall cycles; no extra accepts.
- Boundaries:
  - All scores 0: index 0, value 0.
  - Ascending 1..10: index 9, value 10.
  - 255 at index 9 only, others 254: index 9, value 255.
- Back-to-back: in DONE assert out_ready=1 and start=1 in the same cycle, then stream a second set whose maximum is 77 at index 2. Required: the next cycle is COLLECT with out_valid=0; the second result is index 2, value 77.
- Reset mid-operation: assert rst after the 4th accept. Required: next cycle is IDLE with all outputs zero; in_valid is ignored until start; a fresh run gives the correct result.
- Ignored start: pulse start during COLLECT and during DONE without out_ready. Required: no change to cnt, state, or held outputs.
